// File: rtl/dff_bank_arbiter_if.sv
// Access bus between NREQ requesters and the shared-register arbiter.
// The master side drives requests and write data; the slave side returns the grant and the register contents.
interface dff_bank_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic [OW-1:0]         owner;

   modport master (output req, wdata, input gnt, q, busy, owner);
   modport slave  (input req, wdata, output gnt, q, busy, owner);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register, loaded by the granted requester.
// Optional macro DFF_ARB_BTB_EN: hand the grant straight to the next requester on release (no idle cycle).
module dff_bank_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             reset,
   dff_bank_arbiter_if.slave bus
);
   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned HW = 4;

   typedef enum logic {IDLE, OWN} state_t;

   state_t           r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [WIDTH-1:0] r_q;
   logic             r_busy;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    r_last;
   logic [HW-1:0]    r_hold;

   logic [OW-1:0]    w_win;
   logic [WIDTH-1:0] w_wdata;
   logic             w_own_req;
   logic             w_last_write;
   logic             w_release;

   // First set bit of r, searching upward from last+1 and wrapping modulo NREQ.
   function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] last);
      logic [OW-1:0] pick;
      int unsigned   idx;
      pick = '0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         idx = (32'(last) + k) % NREQ;
         if (r[OW'(idx)]) pick = OW'(idx);
      end
      return pick;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign w_win = rr_pick(bus.req, r_last);

   // Owner's write data; r_gnt is zero outside OWN, so non-owner data never passes.
   always_comb begin
      w_wdata = '0;
      for (int i = 0; i < int'(NREQ); i++)
         if (r_gnt[i]) w_wdata = bus.wdata[i*WIDTH +: WIDTH];
   end

   assign w_own_req    = |(bus.req & r_gnt);
   assign w_last_write = w_own_req && (r_hold == HW'(MAX_HOLD - 1));
   assign w_release    = !w_own_req || w_last_write;

`ifdef DFF_ARB_BTB_EN
   logic [NREQ-1:0] w_others;
   logic [OW-1:0]   w_next;
   assign w_others = bus.req & ~r_gnt;
   assign w_next   = rr_pick(w_others, r_owner);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_q     <= '0;
         r_busy  <= 1'b0;
         r_owner <= '0;
         r_last  <= OW'(NREQ - 1);
         r_hold  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|bus.req) begin
                  r_gnt   <= onehot(w_win);
                  r_owner <= w_win;
                  r_last  <= w_win;
                  r_hold  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= OWN;
               end
            end
            OWN: begin
               if (w_own_req) begin
                  r_q    <= w_wdata;
                  r_hold <= r_hold + HW'(1);
               end
               if (w_release) begin
`ifdef DFF_ARB_BTB_EN
                  if (|w_others) begin
                     r_gnt   <= onehot(w_next);
                     r_owner <= w_next;
                     r_last  <= w_next;
                     r_hold  <= '0;
                  end else begin
                     r_gnt   <= '0;
                     r_owner <= '0;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
`else
                  r_gnt   <= '0;
                  r_owner <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt   = r_gnt;
   assign bus.q     = r_q;
   assign bus.busy  = r_busy;
   assign bus.owner = r_owner;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (NREQ=4, WIDTH=8, MAX_HOLD=4); define DFF_ARB_BTB_EN for the back-to-back build.
module tb_dff_bank_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   dff_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

   dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wd(input int idx, input logic [7:0] v);
      bus.wdata[idx*8 +: 8] = v;
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.req = '0; bus.wdata = '0;
      for (int c = 0; c < 5; c++) begin
         if (c == 3) reset = 1'b1;
         tick();
         checks++;
         if (bus.gnt !== 4'b0000 || bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
            errors++;
            $display("FAIL reset c=%0d: gnt=%b q=%h busy=%b owner=%0d, required 0000/00/0/0",
                     c, bus.gnt, bus.q, bus.busy, bus.owner);
         end
      end
   endtask

   task automatic test_single();
      bus.req = 4'b0100; set_wd(2, 8'hA5);
      tick();
      checks++;
      if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || bus.busy !== 1'b1 || bus.q !== 8'h00) begin
         errors++;
         $display("FAIL single_grant: gnt=%b owner=%0d busy=%b q=%h, required 0100/2/1/00",
                  bus.gnt, bus.owner, bus.busy, bus.q);
      end
      tick();
      checks++;
      if (bus.q !== 8'hA5) begin errors++; $display("FAIL single_w1: q=%h, required a5", bus.q); end
      set_wd(2, 8'h5A);
      tick();
      checks++;
      if (bus.q !== 8'h5A || bus.gnt !== 4'b0100) begin
         errors++; $display("FAIL single_w2: q=%h gnt=%b, required 5a/0100", bus.q, bus.gnt);
      end
      bus.req = 4'b0000; set_wd(2, 8'hEE);
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0 || bus.q !== 8'h5A) begin
         errors++;
         $display("FAIL single_release: gnt=%b busy=%b owner=%0d q=%h, required 0000/0/0/5a",
                  bus.gnt, bus.busy, bus.owner, bus.q);
      end
   endtask

   task automatic test_hold_cap();
      bus.req = 4'b0010; set_wd(1, 8'd1); set_wd(0, 8'hF0); set_wd(2, 8'hF2); set_wd(3, 8'hF3);
      tick();
      checks++;
      if (bus.gnt !== 4'b0010 || bus.q !== 8'h5A) begin
         errors++; $display("FAIL hold_grant: gnt=%b q=%h, required 0010/5a", bus.gnt, bus.q);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (bus.q !== 8'(k) || bus.gnt !== ((k < 4) ? 4'b0010 : 4'b0000)) begin
            errors++;
            $display("FAIL hold_w%0d: q=%h gnt=%b, required %h/%b", k, bus.q, bus.gnt, 8'(k),
                     (k < 4) ? 4'b0010 : 4'b0000);
         end
         set_wd(1, 8'(k + 1));
      end
      tick();
      checks++;
      if (bus.gnt !== 4'b0010 || bus.q !== 8'd4) begin
         errors++; $display("FAIL hold_regrant: gnt=%b q=%h, required 0010/04", bus.gnt, bus.q);
      end
      tick();
      checks++;
      if (bus.q !== 8'd5) begin errors++; $display("FAIL hold_w5: q=%h, required 05", bus.q); end
      bus.req = 4'b0000;
      tick();
   endtask

`ifndef DFF_ARB_BTB_EN
   task automatic test_all_requesting();
      int order [5] = '{0, 1, 2, 3, 0};
      reset = 1'b0; bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) set_wd(i, 8'hFF);
      tick(); tick();
      reset = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (bus.gnt !== 4'(1 << order[n]) || bus.owner !== 2'(order[n]) || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL all_grant%0d: gnt=%b owner=%0d busy=%b, required %b/%0d/1",
                     n, bus.gnt, bus.owner, bus.busy, 4'(1 << order[n]), order[n]);
         end
         for (int k = 0; k < 4; k++) begin
            set_wd(order[n], 8'(16 * order[n] + k + 1));
            tick();
            checks++;
            if (bus.q !== 8'(16 * order[n] + k + 1) || bus.gnt !== ((k < 3) ? 4'(1 << order[n]) : 4'b0000)) begin
               errors++;
               $display("FAIL all_write%0d_%0d: q=%h gnt=%b, required %h/%b", n, k, bus.q, bus.gnt,
                        8'(16 * order[n] + k + 1), (k < 3) ? 4'(1 << order[n]) : 4'b0000);
            end
            set_wd(order[n], 8'hFF);
         end
      end
   endtask
`else
   task automatic test_back_to_back();
      int order [5] = '{0, 3, 0, 3, 0};
      reset = 1'b0; bus.req = 4'b1001;
      for (int i = 0; i < 4; i++) set_wd(i, 8'hFF);
      tick(); tick();
      reset = 1'b1;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL btb_first: gnt=%b busy=%b, required 0001/1", bus.gnt, bus.busy);
      end
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < 4; k++) begin
            set_wd(order[n], 8'(16 * n + k + 1));
            tick();
            checks++;
            if (bus.q !== 8'(16 * n + k + 1) || bus.busy !== 1'b1 ||
                bus.gnt !== ((k < 3) ? 4'(1 << order[n]) : 4'(1 << order[n+1]))) begin
               errors++;
               $display("FAIL btb_write%0d_%0d: q=%h busy=%b gnt=%b, required %h/1/%b", n, k, bus.q,
                        bus.busy, bus.gnt, 8'(16 * n + k + 1),
                        (k < 3) ? 4'(1 << order[n]) : 4'(1 << order[n+1]));
            end
            set_wd(order[n], 8'hFF);
         end
      end
   endtask
`endif

   task automatic test_async_reset();
      bus.req = 4'b1000; set_wd(3, 8'h3C);
      tick();
      checks++;
      if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3) begin
         errors++; $display("FAIL async_grant3: gnt=%b owner=%0d, required 1000/3", bus.gnt, bus.owner);
      end
      tick();
      checks++;
      if (bus.q !== 8'h3C) begin errors++; $display("FAIL async_q3c: q=%h, required 3c", bus.q); end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 4'b0000 || bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
         errors++;
         $display("FAIL async_clear: gnt=%b q=%h busy=%b owner=%0d, required 0000/00/0/0",
                  bus.gnt, bus.q, bus.busy, bus.owner);
      end
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3 || bus.q !== 8'h00) begin
         errors++;
         $display("FAIL async_regrant: gnt=%b owner=%0d q=%h, required 1000/3/00", bus.gnt, bus.owner, bus.q);
      end
      set_wd(3, 8'h77);
      tick();
      checks++;
      if (bus.q !== 8'h77) begin errors++; $display("FAIL async_write: q=%h, required 77", bus.q); end
      bus.req = 4'b0000;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_hold_cap();
`ifndef DFF_ARB_BTB_EN
      test_all_requesting();
`else
      test_back_to_back();
`endif
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
